// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared op/state encodings and datapath width for the pipeline
package pipe_pkg;

    localparam int DW = 16;

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    typedef logic [1:0] op_t;

    function automatic logic is_mem(input op_t op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the MEM stage and the memory
interface mem_stage_if #(
    parameter int DW = pipe_pkg::DW
);
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register; a non-load cycle or reset leaves a bubble
module mem_wb_latch #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          ld_ctr_sig,
    input  logic [DW-1:0] ld_mem_src,
    input  logic [DW-1:0] ld_alu_src,
    input  logic [2:0]    ld_dr,
    input  logic          ld_en,
    output logic          valid,
    output logic          ctr_sig,
    output logic [DW-1:0] mem_src,
    output logic [DW-1:0] alu_src,
    output logic [2:0]    dr,
    output logic          en
);
    logic en_q;

    // Overwrite the latch every edge: a new entry when loading, otherwise a cleared bubble
    always_ff @(posedge clk) begin
        if (!rst_n || !load) begin
            valid   <= 1'b0;
            ctr_sig <= 1'b0;
            mem_src <= '0;
            alu_src <= '0;
            dr      <= '0;
            en_q    <= 1'b0;
        end else begin
            valid   <= 1'b1;
            ctr_sig <= ld_ctr_sig;
            mem_src <= ld_mem_src;
            alu_src <= ld_alu_src;
            dr      <= ld_dr;
            en_q    <= ld_en;
        end
    end

    assign en = valid & en_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage issuing loads/stores over a req/ack port and filling MEM/WB
module mem_stage import pipe_pkg::*; #(
    parameter int DW       = pipe_pkg::DW,
    parameter int MAX_WAIT = 15
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          ex_valid,
    input  logic [1:0]    ex_op,
    input  logic [DW-1:0] ex_addr,
    input  logic [DW-1:0] ex_store_data,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [2:0]    ex_dr,
    input  logic          ex_wb_en,
    output logic          mem_stall,
    mem_stage_if.master   dmem,
    output logic          wb_valid,
    output logic          wb_ctr_sig,
    output logic [DW-1:0] wb_mem_src,
    output logic [DW-1:0] wb_alu_src,
    output logic [2:0]    wb_dr,
    output logic          wb_en,
    output logic          mem_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [DW-1:0] alu_q;
    logic [2:0]    dr_q;
    logic          en_q;

    logic          accept;
    logic          ack;
    logic          tout;
    logic          done;
    logic          load;
    logic          ld_ctr_sig;
    logic [DW-1:0] ld_mem_src;
    logic [DW-1:0] ld_alu_src;
    logic [2:0]    ld_dr;
    logic          ld_en;

    assign mem_stall = state == S_WAIT;

    // Classify this cycle (accept / ack / timeout) and assemble the MEM/WB latch inputs
    always_comb begin
        accept     = state == S_IDLE && ex_valid;
        ack        = state == S_WAIT && dmem.dmem_ack;
        tout       = state == S_WAIT && !dmem.dmem_ack && cnt == CW'(MAX_WAIT - 1);
        done       = ack || tout;
        load       = (accept && !is_mem(ex_op)) || done;
        ld_ctr_sig = state == S_WAIT && op_q == OP_LOAD;
        ld_mem_src = ack && op_q == OP_LOAD ? dmem.dmem_rdata : '0;
        ld_alu_src = state == S_WAIT ? alu_q : ex_alu_result;
        ld_dr      = state == S_WAIT ? dr_q : ex_dr;
        ld_en      = state == S_WAIT ? ack && op_q == OP_LOAD && en_q : ex_wb_en;
    end

    // FSM, wait counter, held request registers and the sticky timeout flag
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            cnt             <= '0;
            op_q            <= OP_NONE;
            alu_q           <= '0;
            dr_q            <= '0;
            en_q            <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            mem_err         <= 1'b0;
        end else begin
            if (accept && is_mem(ex_op)) begin
                state           <= S_WAIT;
                cnt             <= '0;
                op_q            <= ex_op;
                alu_q           <= ex_alu_result;
                dr_q            <= ex_dr;
                en_q            <= ex_wb_en;
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= ex_op == OP_STORE;
                dmem.dmem_addr  <= ex_addr;
                dmem.dmem_wdata <= ex_store_data;
            end else if (done) begin
                state         <= S_IDLE;
                cnt           <= '0;
                dmem.dmem_req <= 1'b0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (tout)
                mem_err <= 1'b1;
        end
    end

    mem_wb_latch #(.DW(DW)) u_wb (
        .clk        (CLOCK_50),
        .rst_n      (reset_n),
        .load       (load),
        .ld_ctr_sig (ld_ctr_sig),
        .ld_mem_src (ld_mem_src),
        .ld_alu_src (ld_alu_src),
        .ld_dr      (ld_dr),
        .ld_en      (ld_en),
        .valid      (wb_valid),
        .ctr_sig    (wb_ctr_sig),
        .mem_src    (wb_mem_src),
        .alu_src    (wb_alu_src),
        .dr         (wb_dr),
        .en         (wb_en)
    );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level model
module tb_mem_stage;
    localparam int MW = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [15:0] ex_addr;
    logic [15:0] ex_store_data;
    logic [15:0] ex_alu_result;
    logic [2:0]  ex_dr;
    logic        ex_wb_en;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_ctr_sig;
    logic [15:0] wb_mem_src;
    logic [15:0] wb_alu_src;
    logic [2:0]  wb_dr;
    logic        wb_en;
    logic        mem_err;

    mem_stage_if #(.DW(16)) dif ();

    mem_stage #(.DW(16), .MAX_WAIT(MW)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset_n       (reset_n),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_alu_result (ex_alu_result),
        .ex_dr         (ex_dr),
        .ex_wb_en      (ex_wb_en),
        .mem_stall     (mem_stall),
        .dmem          (dif),
        .wb_valid      (wb_valid),
        .wb_ctr_sig    (wb_ctr_sig),
        .wb_mem_src    (wb_mem_src),
        .wb_alu_src    (wb_alu_src),
        .wb_dr         (wb_dr),
        .wb_en         (wb_en),
        .mem_err       (mem_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: one outstanding access at most, tracked by its age in wait cycles
    bit          known = 0;
    bit          m_rst = 0;
    bit          busy = 0;
    bit          err = 0;
    int          age = 0;
    logic [1:0]  p_op;
    logic [15:0] p_alu;
    logic [2:0]  p_dr;
    logic        p_en;
    logic        e_req, e_we, e_valid, e_ctr, e_en;
    logic [15:0] e_addr, e_wdata, e_mem, e_alu;
    logic [2:0]  e_dr;

    task automatic set_wb(input logic v, input logic c, input logic [15:0] m,
                          input logic [15:0] a, input logic [2:0] d, input logic en);
        e_valid = v; e_ctr = c; e_mem = m; e_alu = a; e_dr = d; e_en = en;
    endtask

    always @(posedge CLOCK_50) begin
        m_rst = !reset_n;
        if (!reset_n) begin
            known = 1; busy = 0; err = 0; age = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            set_wb(0, 0, 0, 0, 0, 0);
        end else if (busy) begin
            age++;
            if (dif.dmem_ack || age == MW) begin
                if (!dif.dmem_ack) err = 1;
                busy = 0;
                e_req = 0;
                set_wb(1, p_op == 2'd1, (dif.dmem_ack && p_op == 2'd1) ? dif.dmem_rdata : 16'h0,
                       p_alu, p_dr, dif.dmem_ack && p_op == 2'd1 && p_en);
            end else begin
                set_wb(0, 0, 0, 0, 0, 0);
            end
        end else if (ex_valid && (ex_op == 2'd1 || ex_op == 2'd2)) begin
            busy = 1; age = 0;
            p_op = ex_op; p_alu = ex_alu_result; p_dr = ex_dr; p_en = ex_wb_en;
            e_req = 1; e_we = ex_op == 2'd2; e_addr = ex_addr; e_wdata = ex_store_data;
            set_wb(0, 0, 0, 0, 0, 0);
        end else if (ex_valid) begin
            set_wb(1, 0, 0, ex_alu_result, ex_dr, ex_wb_en);
        end else begin
            set_wb(0, 0, 0, 0, 0, 0);
        end
    end

    // Compare DUT outputs with the model each cycle, on the falling edge
    always @(negedge CLOCK_50) begin
        if (known) begin
            chk("dmem_req", 16'(dif.dmem_req), 16'(e_req));
            chk("mem_stall", 16'(mem_stall), 16'(busy));
            chk("wb_valid", 16'(wb_valid), 16'(e_valid));
            chk("wb_en", 16'(wb_en), 16'(e_en));
            chk("mem_err", 16'(mem_err), 16'(err));
            if (e_req || m_rst) begin
                chk("dmem_we", 16'(dif.dmem_we), 16'(e_we));
                chk("dmem_addr", dif.dmem_addr, e_addr);
                chk("dmem_wdata", dif.dmem_wdata, e_wdata);
            end
            if (e_valid || m_rst) begin
                chk("wb_ctr_sig", 16'(wb_ctr_sig), 16'(e_ctr));
                chk("wb_alu_src", wb_alu_src, e_alu);
                chk("wb_dr", 16'(wb_dr), 16'(e_dr));
            end
            if ((e_valid && e_ctr) || m_rst)
                chk("wb_mem_src", wb_mem_src, e_mem);
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] alu, input logic [2:0] r, input logic en);
        ex_valid = 1; ex_op = op; ex_addr = a; ex_store_data = d;
        ex_alu_result = alu; ex_dr = r; ex_wb_en = en;
    endtask

    initial begin
        reset_n = 0;
        issue(2'd1, 16'h5555, 16'h6666, 16'h7777, 3'd7, 1'b1);
        dif.dmem_ack = 0;
        dif.dmem_rdata = 16'h0;
        step();
        step();
        chk("t1_req", 16'(dif.dmem_req), 16'h0);
        chk("t1_stall", 16'(mem_stall), 16'h0);
        chk("t1_valid", 16'(wb_valid), 16'h0);
        chk("t1_err", 16'(mem_err), 16'h0);
        chk("t1_addr", dif.dmem_addr, 16'h0);
        chk("t1_alu", wb_alu_src, 16'h0);

        reset_n = 1;
        issue(2'd0, 16'h0, 16'h0, 16'h1234, 3'd3, 1'b1);
        step();
        chk("t2_valid", 16'(wb_valid), 16'h1);
        chk("t2_ctr", 16'(wb_ctr_sig), 16'h0);
        chk("t2_alu", wb_alu_src, 16'h1234);
        chk("t2_dr", 16'(wb_dr), 16'h3);
        chk("t2_en", 16'(wb_en), 16'h1);

        issue(2'd1, 16'h0040, 16'h0, 16'h0, 3'd5, 1'b1);
        step();
        ex_valid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_req", 16'(dif.dmem_req), 16'h1);
            chk("t3_we", 16'(dif.dmem_we), 16'h0);
            chk("t3_addr", dif.dmem_addr, 16'h0040);
            chk("t3_stall", 16'(mem_stall), 16'h1);
            step();
        end
        chk("t3_stall_last", 16'(mem_stall), 16'h1);
        dif.dmem_ack = 1;
        dif.dmem_rdata = 16'hBEEF;
        step();
        dif.dmem_ack = 0;
        chk("t3_valid", 16'(wb_valid), 16'h1);
        chk("t3_ctr", 16'(wb_ctr_sig), 16'h1);
        chk("t3_mem", wb_mem_src, 16'hBEEF);
        chk("t3_stall_done", 16'(mem_stall), 16'h0);
        chk("t3_en", 16'(wb_en), 16'h1);

        issue(2'd2, 16'h0010, 16'h00AA, 16'h0, 3'd2, 1'b1);
        step();
        ex_valid = 0;
        chk("t4_req", 16'(dif.dmem_req), 16'h1);
        chk("t4_we", 16'(dif.dmem_we), 16'h1);
        chk("t4_wdata", dif.dmem_wdata, 16'h00AA);
        dif.dmem_ack = 1;
        step();
        dif.dmem_ack = 0;
        chk("t4_req_drop", 16'(dif.dmem_req), 16'h0);
        chk("t4_valid", 16'(wb_valid), 16'h1);
        chk("t4_en", 16'(wb_en), 16'h0);

        issue(2'd1, 16'h0077, 16'h0, 16'h0, 3'd1, 1'b1);
        step();
        ex_valid = 0;
        for (int i = 0; i < MW - 1; i++) begin
            chk("t5_req_held", 16'(dif.dmem_req), 16'h1);
            step();
        end
        chk("t5_req_last", 16'(dif.dmem_req), 16'h1);
        step();
        chk("t5_req_drop", 16'(dif.dmem_req), 16'h0);
        chk("t5_err", 16'(mem_err), 16'h1);
        chk("t5_valid", 16'(wb_valid), 16'h1);
        chk("t5_en", 16'(wb_en), 16'h0);
        chk("t5_mem", wb_mem_src, 16'h0);
        step();
        chk("t5_err_sticky", 16'(mem_err), 16'h1);

        issue(2'd1, 16'h0099, 16'h0, 16'h0, 3'd4, 1'b1);
        step();
        ex_valid = 0;
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        chk("t6_req", 16'(dif.dmem_req), 16'h0);
        chk("t6_stall", 16'(mem_stall), 16'h0);
        dif.dmem_ack = 1;
        dif.dmem_rdata = 16'h1111;
        step();
        dif.dmem_ack = 0;
        chk("t6_valid", 16'(wb_valid), 16'h0);

        for (int i = 0; i < 3000; i++) begin
            reset_n = $urandom_range(0, 59) != 0;
            ex_valid = $urandom_range(0, 3) != 0;
            ex_op = 2'($urandom_range(0, 3));
            ex_addr = 16'($urandom);
            ex_store_data = 16'($urandom);
            ex_alu_result = 16'($urandom);
            ex_dr = 3'($urandom_range(0, 7));
            ex_wb_en = 1'($urandom_range(0, 1));
            dif.dmem_ack = $urandom_range(0, 9) < 3;
            dif.dmem_rdata = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage of the 16-bit 5-stage processor, between EXE and WB.
- Takes the EXE result latch, performs data-memory loads and stores over a variable-latency req/ack port, and fills the MEM/WB latch.
- The MEM/WB latch drives WB's inputs (ctr_sig, mem_src, alu_src).
- Stalls upstream while a memory access is outstanding.
- Exposes the MEM/WB latch contents for forwarding to ID.

Parameters:
- DW, 16, datapath/address width.
- MAX_WAIT, 15, cycles to wait for dmem_ack before timing out; must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ex_valid  in  1  EXE latch holds a valid instruction.
- ex_op  in  2  0=ALU/none, 1=LOAD, 2=STORE, 3=reserved (treated as 0).
- ex_addr  in  DW  effective address from EXE.
- ex_store_data  in  DW  store data.
- ex_alu_result  in  DW  ALU result.
- ex_dr  in  3  destination register.
- ex_wb_en  in  1  instruction writes the register file.
- mem_stall  out  1  EXE must hold its latch; combinational from state.
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  1=write; valid while dmem_req=1.
- dmem_addr  out  DW  memory address.
- dmem_wdata  out  DW  write data.
- dmem_rdata  in  DW  read data; valid when dmem_ack=1.
- dmem_ack  in  1  one-cycle completion pulse.
- wb_valid  out  1  MEM/WB latch valid.
- wb_ctr_sig  out  1  WB select: 1=mem_src, 0=alu_src.
- wb_mem_src  out  DW  loaded data.
- wb_alu_src  out  DW  ALU result.
- wb_dr  out  3  destination register.
- wb_en  out  1  register-file write enable (wb_valid & latched wb_en).
- mem_err  out  1  sticky timeout flag.

Behaviour:

Reset and states:
- Reset is synchronous and active-low on CLOCK_50. While reset_n=0 at a clock edge:
  - all outputs are 0 at the next edge, including dmem_req, wb_valid, mem_err and all data fields;
  - state=IDLE and the wait counter is 0.
- FSM has two states, IDLE and WAIT. mem_stall = (state==WAIT).

IDLE:
- Accept when ex_valid=1. mem_stall is 0 in IDLE, so acceptance is unconditional.
- ex_op=0 or 3:
  - at the next edge, load MEM/WB latch: wb_valid=1, wb_ctr_sig=0, wb_alu_src=ex_alu_result, wb_dr=ex_dr, wb_en=ex_wb_en;
  - latency is 1 cycle.
- ex_op=1 or 2:
  - at the next edge, state→WAIT and dmem_req=1;
  - dmem_addr=ex_addr, dmem_we=(ex_op==2), dmem_wdata=ex_store_data;
  - capture alu_result, dr, wb_en and op internally;
  - wb_valid=0 (bubble).
- ex_valid=0: wb_valid=0 at the next edge.

WAIT:
- dmem_req, dmem_addr, dmem_we and dmem_wdata are held stable.
- Counter increments every cycle in WAIT.
- dmem_ack=1 at an edge:
  - state→IDLE, dmem_req=0, counter=0;
  - MEM/WB latch loaded with wb_valid=1.
  - LOAD: wb_ctr_sig=1, wb_mem_src=dmem_rdata, wb_en=captured wb_en.
  - STORE: wb_ctr_sig=0, wb_en=0.
- Counter reaches MAX_WAIT with no ack:
  - behave as ack with rdata=0;
  - set mem_err=1 (sticky until reset);
  - force wb_en=0.
- ack and timeout in the same cycle: ack wins, mem_err unchanged.

Other rules:
- dmem_ack while in IDLE is ignored.
- Minimum LOAD latency is 2 cycles: request edge, then ack edge.
- Back-to-back memory ops: the second is accepted on the cycle after returning to IDLE.
- Reset asserted in WAIT: dmem_req=0 at that edge and the outstanding access is abandoned. The memory must tolerate a dropped request.
- The MEM/WB latch holds one entry per cycle and is overwritten every edge. WB never stalls.

Decomposition:
- Shared package pipe_pkg holds:
  - op encodings OP_NONE=0, OP_LOAD=1, OP_STORE=2;
  - FSM state encodings;
  - DW=16.
- One natural sub-module: mem_wb_latch, the MEM/WB register with its reset and load-enable.
- FSM and counter live in mem_stage.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with ex_valid=1. Required: all outputs 0, mem_stall=0.
2. ALU pass-through: ex_op=0, ex_alu_result=16'h1234, ex_dr=3, ex_wb_en=1. Required next cycle: wb_valid=1, wb_ctr_sig=0, wb_alu_src=16'h1234, wb_dr=3, wb_en=1.
3. LOAD with ack 3 cycles after req, ex_addr=16'h0040, dmem_rdata=16'hBEEF:
   - during wait: dmem_req=1, dmem_we=0, dmem_addr=16'h0040, mem_stall=1;
   - next cycle after ack: wb_ctr_sig=1, wb_mem_src=16'hBEEF, mem_stall=0.
4. STORE ex_addr=16'h0010, ex_store_data=16'h00AA, immediate ack. Required:
   - dmem_we=1, dmem_wdata=16'h00AA for exactly one req cycle;
   - then wb_valid=1, wb_en=0.
5. Timeout with MAX_WAIT=4 and no ack. Required:
   - dmem_req drops after 4 WAIT cycles;
   - mem_err=1 and stays 1;
   - wb_en=0.
6. Reset mid-WAIT: assert reset_n=0 on the 2nd WAIT cycle. Required: dmem_req=0 the next cycle and state IDLE. A later ack pulse produces no wb_valid.
